// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, size codes and lane extract/merge helpers for
//               the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Little-endian lane select, zero- or sign-extended to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sign);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {off, 3'b000};
    res = word;
    case (size)
      SZ_B: res = {{24{sign & sh[7]}}, sh[7:0]};
      SZ_H: begin
        sh  = word >> {off[1], 4'b0000};
        res = {{16{sign & sh[15]}}, sh[15:0]};
      end
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size,
                                             input logic [31:0] data);
    logic [31:0] mask;
    logic [31:0] ins;
    case (size)
      SZ_B: begin
        mask = 32'h0000_00FF << {off, 3'b000};
        ins  = {24'd0, data[7:0]} << {off, 3'b000};
      end
      SZ_H: begin
        mask = 32'h0000_FFFF << {off[1], 4'b0000};
        ins  = {16'd0, data[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ins  = data;
      end
    endcase
    return (word & ~mask) | ins;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane.sv
// ============================================================================
// Module      : lsu_lane
// Description : Combinational lane unit: load extraction and store merge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  input  logic [31:0] i_data,
  output logic [31:0] o_ext,
  output logic [31:0] o_merged
);

  assign o_ext    = lane_extract(i_word, i_off, i_size, i_sign);
  assign o_merged = lane_merge(i_word, i_off, i_size, i_data);

endmodule

`default_nettype wire

// File: rtl/lsu_rmw.sv
// ============================================================================
// Module      : lsu_rmw
// Description : Load/store initiator with read-modify-write for sub-word
//               stores. Optional trace output under macro LSU_TRACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_sign,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [31:0]   req_pc,
  output logic          busy,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          addr_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_t        r_state;
  state_t        w_next;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_sign;
  logic          r_err;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_merge;
  logic [31:0]   r_rdata;
  logic          w_err;
  logic          w_accept;
  logic [31:0]   w_ext;
  logic [31:0]   w_merged;

  assign w_err = (req_size == 2'b11)
               | ((req_size == SZ_H) & req_addr[0])
               | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
               | (req_addr[31:AW+2] != '0);

  assign w_accept = (r_state == ST_IDLE) & req;

  lsu_lane u_lane (
    .i_word   (mem_rdata),
    .i_off    (r_addr[1:0]),
    .i_size   (r_size),
    .i_sign   (r_sign),
    .i_data   (r_wdata),
    .o_ext    (w_ext),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_size  <= SZ_B;
      r_sign  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_merge <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_sign  <= req_sign;
        r_err   <= w_err;
        r_addr  <= req_addr[AW+1:0];
        r_wdata <= req_wdata;
        if (w_err && !req_we) begin
          r_rdata <= '0;
        end
      end
      if (r_state == ST_RD) begin
        if (r_we) begin
          r_merge <= w_merged;
        end else begin
          r_rdata <= w_ext;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (w_err) begin
            w_next = ST_DONE;
          end else if (!req_we || (req_size != SZ_W)) begin
            w_next = ST_RD;
          end else begin
            w_next = ST_WR;
          end
        end
      end
      ST_RD:   w_next = r_we ? ST_WR : ST_DONE;
      ST_WR:   w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign addr_err  = done & r_err;
  assign rdata     = r_rdata;
  // Gating by reset stops a write committing on the same edge that aborts an RMW.
  assign mem_we    = (r_state == ST_WR) & ~reset;
  assign mem_addr  = ((r_state == ST_RD) || (r_state == ST_WR)) ? r_addr[AW+1:2] : '0;
  assign mem_wdata = (r_state == ST_WR) ? ((r_size == SZ_W) ? r_wdata : r_merge) : '0;

`ifdef LSU_TRACE_EN
  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
    end else begin
      if (w_accept) begin
        r_pc <= req_pc;
      end
      if (r_state == ST_WR) begin
        $display("@%h: *%h <= %h", r_pc, {mem_addr, 2'b00}, mem_wdata);
      end
      if (w_accept && w_err) begin
        $display("@%h: addr_err %h", req_pc, req_addr);
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^req_pc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_rmw.sv
// ============================================================================
// Module      : tb_lsu_rmw
// Description : Scoreboard bench for lsu_rmw with a byte-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_rmw;

  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_sign;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [31:0]   req_pc;
  logic          busy;
  logic          done;
  logic [31:0]   rdata;
  logic          addr_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  lsu_rmw #(.AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sign  (req_sign),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_pc    (req_pc),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .addr_err  (addr_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory seen by the DUT; written only from this process.
  logic [31:0] mem [DEPTH];
  logic        init_en;
  logic        poke_en;
  int          poke_idx;
  logic [31:0] poke_val;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_5A5A;
    end else begin
      if (poke_en) mem[poke_idx] <= poke_val;
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          nwr;
    int          idx;
    logic [31:0] word;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] mdl_rdata;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the address/size rules, byte by byte.
  function automatic exp_t predict(input logic we, input logic [1:0] size,
                                   input logic sign, input logic [31:0] addr,
                                   input logic [31:0] wdata);
    exp_t        e;
    int          nb;
    int          off;
    logic [31:0] w;
    logic [31:0] val;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    e.idx = int'((addr / 4) % DEPTH);
    e.err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
            (size == 2'd2 && addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
    e.nwr = 0;
    w = ref_mem[e.idx];
    if (e.err) begin
      e.lat = 1;
      if (!we) mdl_rdata = 32'd0;
    end else if (!we) begin
      e.lat = 2;
      val = 32'd0;
      for (int k = 0; k < nb; k++) val[8*k +: 8] = w[8*(off+k) +: 8];
      if (sign && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      mdl_rdata = val;
    end else begin
      e.lat = (nb == 4) ? 2 : 3;
      e.nwr = 1;
      for (int k = 0; k < nb; k++) w[8*(off+k) +: 8] = wdata[8*k +: 8];
      ref_mem[e.idx] = w;
    end
    e.rd   = mdl_rdata;
    e.word = ref_mem[e.idx];
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse.
  int   mon_busy = 0;
  int   mon_we   = 0;
  logic mon_prev_done = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      mon_busy = 0;
      mon_we   = 0;
      mon_prev_done = 1'b0;
    end else begin
      if (busy) mon_busy++;
      if (mem_we) mon_we++;
      if (done) begin
        chk("done_width", 32'(mon_prev_done), 32'd0);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no transaction");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("addr_err", 32'(addr_err), 32'(e.err));
          chk("rdata", rdata, e.rd);
          chk("latency", 32'(mon_busy), 32'(e.lat));
          chk("mem_writes", 32'(mon_we), 32'(e.nwr));
          chk("mem_word", mem[e.idx], e.word);
        end
        mon_busy = 0;
        mon_we   = 0;
      end
      mon_prev_done = done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1, expected 0");
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req       = 1'b1;
    req_we    = we;
    req_size  = size;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = 32'h0000_1000 + 32'(cyc) * 4;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    wait_idle();
    drive(we, size, sign, addr, wdata);
    sbq.push_back(predict(we, size, sign, addr, wdata));
    @(posedge clk);
    #1 req = 1'b0;
    wait_empty();
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    poke_idx = idx;
    poke_val = val;
    poke_en  = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   t1;
    int   t2;
    int   n;
    logic [1:0] sz;
    logic [31:0] ad;
    int   r;

    reset = 1'b1; init_en = 1'b1; poke_en = 1'b0; poke_idx = 0; poke_val = '0;
    req = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
    req_addr = '0; req_wdata = '0; req_pc = '0;
    mdl_rdata = 32'd0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_5A5A;
    repeat (3) @(posedge clk);
    #1;
    init_en = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", 32'({busy, done, addr_err, mem_we}), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);

    // Directed cases around word 3 / word 4.
    poke(3, 32'h8899_AABB);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_000D, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_000D, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_000E, 32'h0000_1234);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'h5555_5555);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 32'h0000_0008, 32'h7777_7777);

    for (int i = 0; i < 150; i++) begin
      r  = int'($urandom % 16);
      sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      ad = ($urandom % 20 == 0) ? $urandom : ($urandom % 64);
      issue(1'($urandom % 2), sz, 1'($urandom % 2), ad, $urandom);
    end

    // Reset during the WR cycle of an RMW byte store.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0);
    poke(5, 32'h1122_3344);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0);
    wait_idle();
    drive(1'b1, 2'b00, 1'b0, 32'h0000_0015, 32'h0000_00EE);
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("we_gated", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    mdl_rdata = 32'd0;
    chk("post_reset_ctrl", 32'({busy, done, addr_err, mem_we}), 32'd0);
    chk("post_reset_rdata", rdata, 32'd0);
    chk("post_reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("post_reset_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    chk("reset_no_write", mem[5], 32'h1122_3344);

    // req held high through DONE: second load accepted after one IDLE cycle.
    wait_idle();
    drive(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0);
    sbq.push_back(predict(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0));
    sbq.push_back(predict(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0));
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc;
    @(negedge clk);
    chk("idle_gap", 32'(busy), 32'd0);
    @(posedge clk);
    #1 req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    t2 = cyc;
    chk("b2b_spacing", 32'(t2 - t1), 32'd3);
    wait_empty();
    repeat (6) @(negedge clk);
    chk("no_extra_txn", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store initiator between the CPU datapath and the word-organised data memory. Accepts byte, halfword and word load/store requests, checks alignment and range, and issues word-wide reads and writes to the memory port. Sub-word stores use an internal read-modify-write sequence. The CPU stalls on `busy` and consumes the result on `done`.

## Interface
Parameters:
- `AW`, 11: word-address width; memory depth is 2^AW words.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `req`, in, 1: request; sampled only in IDLE.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_size`, in, 2: 00 byte, 01 halfword, 10 word; 11 is an error.
- `req_sign`, in, 1: sign-extend load result (lb/lh); ignored for word and stores.
- `req_addr`, in, 32: byte address.
- `req_wdata`, in, 32: store data; the low bytes are used for sub-word stores.
- `req_pc`, in, 32: PC of the issuing instruction, used for trace.
- `busy`, out, 1: high while state ≠ IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `rdata`, out, 32: load result, registered.
- `addr_err`, out, 1: valid with `done`; set on misalignment, range error or bad size.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, AW: memory word index.
- `mem_wdata`, out, 32: memory write data.
- `mem_rdata`, in, 32: memory read data; combinational from `mem_addr`.

## Operation
- States: IDLE, RD, WR, DONE; state is registered.
- IDLE with `req` high latches `op`, `addr`, `wdata`, `pc`. Next state:
  - error → DONE with `addr_err` = 1;
  - load, or sub-word store → RD;
  - word store → WR.
- Error conditions:
  - size 11;
  - halfword with `addr[0]` = 1;
  - word with `addr[1:0]` ≠ 0;
  - `addr[31:AW+2]` ≠ 0.
- `mem_addr` = latched `addr[AW+1:2]`, driven in RD and WR.
- RD, load: `rdata` ← extracted result. Next state is DONE.
  - Byte: lane at bits 8·`addr[1:0]`+7 : 8·`addr[1:0]`. Halfword: lane at bits 16·`addr[1]`+15 : 16·`addr[1]`. Little-endian.
  - Result is zero-extended, or sign-extended when `req_sign` = 1.
- RD, sub-word store: merge register ← `mem_rdata` with the target lane replaced by `wdata[7:0]` or `wdata[15:0]`. Next state is WR.
- WR: `mem_we` = 1 and `mem_wdata` = merged word (word store: `wdata`). Next state is DONE.
- DONE: `done` = 1. Next state is always IDLE; `req` is not sampled in DONE.
- `rdata` changes only on load completion; a load error sets `rdata` = 0.
- `req` outside IDLE is ignored.
- Reset:
  - Returns the FSM to IDLE at the clock edge.
  - `mem_we` is gated by `~reset` combinationally, so no write commits during a reset cycle, including mid-RMW.
- Reset values: `busy` 0, `done` 0, `rdata` 0, `addr_err` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0.

## Timing
- Request sampled at edge N:
  - error: `done` in cycle N+1;
  - load: RD in N+1, `done` in N+2;
  - word store: WR in N+1, `done` in N+2;
  - sub-word store: RD in N+1, WR in N+2, `done` in N+3.
- `busy` is high from cycle N+1 through the DONE cycle inclusive.
- Back-to-back requests: the earliest next acceptance is the edge ending the first IDLE cycle after DONE.
- `mem_addr` and `mem_wdata` are stable for the whole WR cycle. The memory commits at the edge ending WR.

## Configuration
- `LSU_TRACE_EN` defined: at the edge ending WR (unless `reset`), `$display("@%h: *%h <= %h", pc, {mem_addr,2'b00}, mem_wdata)`. Additionally, on each error, `$display("@%h: addr_err %h", pc, addr)`.
- Undefined: no display statements; behaviour is otherwise identical.

## Structure
- Package `lsu_pkg` holds:
  - state encoding typedef;
  - size codes `SZ_B`, `SZ_H`, `SZ_W`;
  - function `lane_extract(word, off, size, sign)`;
  - function `lane_merge(word, off, size, data)`.
- One sub-module, `lsu_lane`, is natural: the combinational extract/merge unit, instantiated once and shared by RD (load) and RMW.

## Test plan
- Memory word 3 = 0x8899AABB. lb at 0x0000000D (sign) → `rdata` 0xFFFFFFAA, `done` at N+2. lbu → 0x000000AA.
- Word 3 = 0x8899AABB; sh 0x1234 at 0x0000000E → RD at N+1, WR at N+2, word 3 = 0x1234AABB, `done` at N+3.
- sw 0xDEADBEEF at 0x00000010 → single WR at N+1, word 4 = 0xDEADBEEF, `done` at N+2; no RD cycle.
- Each of these → `done` at N+1, `addr_err` = 1, `mem_we` never high, `rdata` = 0:
  - lh at 0x00000003;
  - sw at 0x00000002;
  - lw at 0x00002000 (AW = 11);
  - size 11.
- `reset` asserted during WR of an sb → no memory change, next cycle `busy` = 0 and all outputs at reset values.
- `req` held high through DONE → the second transaction is accepted only after one IDLE cycle; `done` pulses are exactly one cycle each.
